// File: rtl/tsm_pkg.sv
// Shared types and sizing helpers for the time-shared share accumulator.
package tsm_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam int WIDTH_D  = 8;
   localparam int NTERMS_D = 4;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/xor_module.sv
// Single-bit XOR cell.
module xor_module (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = a ^ b;

endmodule

// File: rtl/tsm_share_accum.sv
// XOR-compresses NTERMS serially arriving terms into one output share,
// holding the finished share until the downstream stage takes it.
module tsm_share_accum
   import tsm_pkg::*;
#(
   parameter int WIDTH  = WIDTH_D,
   parameter int NTERMS = NTERMS_D
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_term,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_share,
   input  logic                      out_ready,
   output logic [idx_w(NTERMS)-1:0]  term_idx
);

   localparam int IW = idx_w(NTERMS);
   localparam logic [IW-1:0] LAST = IW'(NTERMS - 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0] xo;
   logic [IW-1:0]    idx_nx;
   logic             accept;

   for (genvar i = 0; i < WIDTH; i++) begin : g_xor
      xor_module u_xor (
         .a (acc[i]),
         .b (in_term[i]),
         .y (xo[i])
      );
   end

   always_comb begin
      state_nx  = state;
      acc_nx    = acc;
      idx_nx    = term_idx;
      in_ready  = 1'b1;
      out_valid = 1'b0;
      accept    = 1'b0;
      unique case (state)
         ACCUM: begin
            in_ready = 1'b1;
         end
         FULL: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_nx = ACCUM;
         end
      endcase
      accept = in_valid & in_ready;
      // Index 0 always loads fresh so shares never mix.
      if (accept) begin
         acc_nx = (term_idx == '0) ? in_term : xo;
         if (term_idx == LAST) begin
            idx_nx   = '0;
            state_nx = FULL;
         end else begin
            idx_nx = term_idx + IW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ACCUM;
         acc      <= '0;
         term_idx <= '0;
      end else begin
         state    <= state_nx;
         acc      <= acc_nx;
         term_idx <= idx_nx;
      end
   end

   assign out_share = acc;

endmodule

// File: tb/tb_tsm_share_accum.sv
// Directed and random checks of tsm_share_accum against a queue-based model.
module tb_tsm_share_accum;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_term;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_share;
   logic       out_ready;
   logic [1:0] term_idx;

   int total = 0;
   int bad   = 0;

   logic [7:0] part[$];
   logic [7:0] shq[$];
   logic [7:0] got;
   int         nshares;
   int         naccept;

   always #5 clk = ~clk;

   tsm_share_accum #(.WIDTH(8), .NTERMS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_term   (in_term),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_share (out_share),
      .out_ready (out_ready),
      .term_idx  (term_idx)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle; inputs applied after the falling edge.
   task automatic cyc(input logic v, input logic [7:0] t, input logic r);
      logic pend;
      logic ok;
      logic [7:0] x;
      in_valid  = v;
      in_term   = t;
      out_ready = r;
      #1;
      pend = (shq.size() != 0);
      chk("in_ready", 32'(in_ready), 32'(!pend || r));
      chk("out_valid", 32'(out_valid), 32'(pend));
      chk("term_idx", 32'(term_idx), 32'(part.size()));
      if (pend) chk("share", 32'(out_share), 32'(shq[0]));
      if (pend && r) begin
         got = shq.pop_front();
         nshares++;
      end
      ok = v && (!pend || r);
      if (ok) begin
         naccept++;
         part.push_back(t);
         if (part.size() == 4) begin
            x = '0;
            foreach (part[i]) x ^= part[i];
            shq.push_back(x);
            part.delete();
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_term   = 8'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      rst = 1'b0;
      part.delete();
      shq.delete();
      in_valid = 1'b0;
      #1;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_idx", 32'(term_idx), 32'd0);
      chk("rst_acc", 32'(out_share), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_term = '0;
      out_ready = 1'b0;
      nshares = 0;
      naccept = 0;
      got = '0;
      @(negedge clk);
      do_reset();

      // basic compression
      cyc(1, 8'h0F, 1);
      cyc(1, 8'hF0, 1);
      cyc(1, 8'h33, 1);
      cyc(1, 8'h55, 1);
      chk("basic_valid", 32'(out_valid), 32'd1);
      cyc(0, 8'h00, 1);
      chk("basic_share", 32'(got), 32'h99);
      cyc(0, 8'h00, 1);

      // backpressure, then back-to-back second batch
      cyc(1, 8'h0F, 1);
      cyc(1, 8'hF0, 1);
      cyc(1, 8'h33, 1);
      cyc(1, 8'h55, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 8'hA5, 0);
         chk("bp_hold", 32'(out_share), 32'h99);
      end
      cyc(1, 8'h01, 1);
      chk("b2b_first", 32'(got), 32'h99);
      chk("b2b_idx", 32'(term_idx), 32'd1);
      cyc(1, 8'h02, 1);
      cyc(1, 8'h04, 1);
      cyc(1, 8'h08, 1);
      cyc(0, 8'h00, 1);
      chk("b2b_second", 32'(got), 32'h0F);

      // gapped input
      cyc(1, 8'hAA, 1);
      cyc(0, 8'h00, 1);
      cyc(0, 8'h00, 1);
      cyc(0, 8'h00, 1);
      cyc(1, 8'hAA, 1);
      cyc(1, 8'hFF, 1);
      cyc(1, 8'h00, 1);
      cyc(0, 8'h00, 1);
      chk("gap_share", 32'(got), 32'hFF);

      // reset mid-accumulation
      cyc(1, 8'h12, 1);
      cyc(1, 8'h34, 1);
      do_reset();
      cyc(1, 8'h11, 1);
      cyc(1, 8'h22, 1);
      cyc(1, 8'h44, 1);
      cyc(1, 8'h88, 1);
      cyc(0, 8'h00, 1);
      chk("rst_share", 32'(got), 32'hFF);

      // reset while a share is pending
      cyc(1, 8'h01, 0);
      cyc(1, 8'h02, 0);
      cyc(1, 8'h03, 0);
      cyc(1, 8'h04, 0);
      cyc(0, 8'h00, 0);
      do_reset();
      cyc(0, 8'h00, 1);

      // random scoreboard
      naccept = 0;
      nshares = 0;
      for (int n = 0; n < 60000 && naccept < 10000; n++)
         cyc(1'($urandom), 8'($urandom), 1'($urandom));
      chk("rand_terms", 32'(naccept >= 10000), 32'd1);
      for (int n = 0; n < 8; n++) cyc(0, 8'h00, 1);
      chk("rand_shares", 32'(nshares), 32'(naccept / 4));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tsm_share_accum.md
TSM_SHARE_ACCUM -- requirements
Module: tsm_share_accum

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of one share term.
REQ-002 Parameter NTERMS, default 4, SHALL set the number of serially arriving terms XOR-compressed into one output share; legal range 2..16.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-005 Port in_valid, input, 1, SHALL mark in_term as holding a valid term.
REQ-006 Port in_term, input, WIDTH, SHALL carry one time-shared partial term from the upstream XOR stage.
REQ-007 Port in_ready, output, 1, SHALL indicate the block accepts a term this cycle.
REQ-008 Port out_valid, output, 1, SHALL mark out_share as a completed compressed share.
REQ-009 Port out_share, output, WIDTH, SHALL carry the XOR of NTERMS accepted terms.
REQ-010 Port out_ready, input, 1, SHALL indicate the downstream stage consumes out_share this cycle.
REQ-011 Port term_idx, output, clog2(NTERMS), SHALL expose the index of the next term to be accepted, for debug and the bench.

Function
REQ-012 A term SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-013 States SHALL be ACCUM, which collects terms, and FULL, which holds a completed share.
REQ-014 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 Accepting term index 0 SHALL load acc with in_term, not with acc XOR in_term.
REQ-016 Accepting index k>0 SHALL set acc to acc XOR in_term.
REQ-017 Each accept SHALL increment term_idx.
REQ-018 Accepting index NTERMS-1 SHALL wrap term_idx to 0 and move the state to FULL.
REQ-019 out_valid SHALL rise exactly one cycle after the NTERMS-th accept.
REQ-020 out_share SHALL be driven directly from the acc register, with no combinational path from in_term to out_share.
REQ-021 In FULL, out_valid SHALL be 1, and out_share and acc SHALL hold stable until out_ready=1.
REQ-022 In FULL, in_ready SHALL equal out_ready (pass-through slot).
REQ-023 FULL with out_ready=1 and no accept SHALL return the state to ACCUM with term_idx=0.
REQ-024 FULL with out_ready=1 and a simultaneous accept SHALL load acc with in_term as index 0, set term_idx=1, and move to ACCUM with no bubble.
REQ-025 FULL with out_ready=0 SHALL ignore in_valid; no term is lost because in_ready=0.
REQ-026 No accept in ACCUM SHALL hold acc and term_idx unchanged; idle gaps between terms are legal.
REQ-027 acc SHALL never be combined with a term from a different output share; index-0 load enforces share separation.

Reset
REQ-028 rst=1 SHALL force state ACCUM, term_idx=0, acc=0, out_valid=0 and in_ready=1 on the next edge.
REQ-029 rst mid-accumulation SHALL discard the partial acc.
REQ-030 rst in FULL SHALL discard the pending share, with no out_valid pulse.
REQ-031 A term presented in the same cycle as rst SHALL be dropped.

Structure
REQ-032 Package tsm_pkg SHALL hold the state enum (ACCUM, FULL), the WIDTH and NTERMS defaults, and a clog2-based index-width function.
REQ-033 The per-bit XOR SHALL be built from WIDTH instances of the existing xor_module cell, generated in a loop, as the only sub-module.
REQ-034 acc, term_idx and state SHALL be the only registers.
REQ-035 The implementation SHALL fit in 120–400 lines of RTL.

Verification
REQ-036 Basic compression: WIDTH=8, NTERMS=4; terms 0x0F, 0xF0, 0x33, 0x55 on consecutive cycles, out_ready=1 -> out_valid for 1 cycle, one cycle after the 4th accept, with out_share=0x99.
REQ-037 Backpressure: same terms, out_ready=0 for 5 cycles -> out_share holds 0x99, in_ready=0 throughout, and a 5th in_valid term is not accepted until out_ready=1.
REQ-038 Back-to-back shares: second batch 0x01, 0x02, 0x04, 0x08, with its first term accepted in the same cycle the first share is consumed -> shares 0x99 and then 0x0F, with no idle cycle between batches.
REQ-039 Gapped input: terms 0xAA, (idle 3 cycles), 0xAA, 0xFF, 0x00 -> out_share=0xFF, and term_idx sequence 0,1,1,1,1,2,3,0.
REQ-040 Reset mid-operation: rst asserted after 2 accepted terms, then terms 0x11, 0x22, 0x44, 0x88 -> out_share=0xFF, with no output from the partial batch.
REQ-041 Random-term scoreboard: 10k random terms with random in_valid and out_ready -> every out_share equals the reference XOR of its 4 terms, and no term is lost or duplicated.
